coin_feeder: RTL and testbench
==============================

# coin_feeder

Front end that drives the `coin1`/`coin2` inputs of the vending machine FSM from raw coin-sensor levels. It synchronises and debounces each sensor channel and queues accepted coins in a small FIFO. It issues single-cycle coin pulses only while the machine can accept them, tracking credit and blocking issue until the machine signals `dispense`. It sits between the coin-slot sensors and the vending machine, and also counts vends and flags protocol errors.

## Interface
- `DEPTH`, 4: coin FIFO entries; power of two, ≥2.
- `DEBOUNCE`, 4: consecutive stable synchronised cycles required to accept or re-arm a channel; ≥1.
- `CNT_W`, 8: width of `vend_count`.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; one clock; reset is synchronous and active-high.
- `raw_coin1` in 1: asynchronous level from the 1-unit coin sensor.
- `raw_coin2` in 1: asynchronous level from the 2-unit coin sensor.
- `dispense` in 1: from the vending machine; high for one cycle per vend.
- `coin1` out 1: registered one-cycle pulse to the vending machine, 1-unit coin.
- `coin2` out 1: registered one-cycle pulse to the vending machine, 2-unit coin.
- `fifo_count` out $clog2(DEPTH)+1: current FIFO occupancy.
- `reject` out 1: one-cycle pulse when an accepted coin event is dropped.
- `vend_count` out CNT_W: number of `dispense` pulses seen in WAIT_VEND; wraps modulo 2^CNT_W.
- `err` out 1: sticky; set by `dispense` seen in FEED; cleared only by reset.

## Operation
- **Reset values:** `coin1`=`coin2`=0, `reject`=0, `err`=0, `vend_count`=0, `fifo_count`=0. FSM is in FEED, credit=0, debounce counters=0, both channels armed, sync flops=0.
- **Sync:** each raw input passes through 2 flops; debounce logic sees only the second flop.
- **Debounce, per channel:**
  - Armed channel: counts consecutive synchronised-high cycles. When the count reaches DEBOUNCE, it raises one coin event and becomes disarmed.
  - Disarmed channel: counts consecutive synchronised-low cycles. When the count reaches DEBOUNCE, it re-arms.
  - Any opposite-level cycle zeroes the count.
  - One event per sensor high period, however long the high lasts.
- **Enqueue:** FIFO entries are 1 bit (0 = coin1, 1 = coin2).
  - Both channels produce events in the same cycle: coin2 is enqueued and coin1 is dropped with `reject`.
  - Event while the FIFO is full: the event is dropped and `reject` pulses.
  - Pop and push in the same cycle on a full FIFO: the push succeeds.
- **Credit:** a 3-bit register, always 0..5. It mirrors the vending machine's accumulated value.
- **FSM states:** FEED, WAIT_VEND.
  - **FEED:** if the FIFO is non-empty, pop the head. Drive `coin1` or `coin2` high for the next cycle and add 1 or 2 to credit. If the new credit is ≥4, go to WAIT_VEND. Otherwise stay in FEED; back-to-back pops on consecutive cycles are allowed.
  - **WAIT_VEND:** no pops; the FIFO keeps accepting pushes. When `dispense`=1: credit←0, `vend_count`+1 (wrapping), go to FEED. The earliest next pop is at the following edge, when the machine is back in its idle state.
  - `dispense` while in FEED: sets `err`; credit and state are unchanged; `vend_count` is unchanged.
- **Invariant:** `coin1` and `coin2` are never high together and never high for more than one cycle per popped entry.
- **Reset mid-operation:** FIFO contents and credit are discarded, and any in-flight pulse is cleared at the reset edge.

## Timing
- `coin1`, `coin2`, `reject`, `fifo_count`, `vend_count` and `err` are all registered.
- Accept latency from edge E0, the first edge to sample a raw input high (held high, FIFO empty, FSM in FEED):
  - The synchronised level is high after E1.
  - The event is enqueued at E1+DEBOUNCE.
  - The pulse output is high in the cycle after edge E2+DEBOUNCE, i.e. 6 edges after E0 for DEBOUNCE=4.
- Pulse spacing: one pop per cycle in FEED.
- `dispense` latency: `dispense` high in cycle t → FEED and credit=0 after the edge ending t → a pulse can be high in cycle t+2.
- Raw glitches shorter than DEBOUNCE synchronised cycles produce no event.

## Test plan
- Reset, then raw_coin1 high for 20 cycles (DEBOUNCE=4) → exactly one `coin1` pulse, high at edge 6 after first sample; `fifo_count` returns to 0; credit=1, FSM stays in FEED.
- raw_coin2 glitch of 3 synchronised cycles, then low 10 cycles → no `coin2`, no `reject`, `fifo_count`=0.
- Enqueue coin2, coin2, coin1 while idle → pulses coin2, coin2 on consecutive cycles. Credit reaches 4 → WAIT_VEND; the coin1 entry stays queued (`fifo_count`=1) until `dispense` is driven for one cycle. `coin1` is then high 2 cycles later and `vend_count`=1.
- Hold the FSM in WAIT_VEND, inject DEPTH+1 coin1 events → `fifo_count`=DEPTH and one `reject` pulse.
- Both channels' events in the same cycle → one coin2 enqueued and `reject` pulses once.
- `dispense` pulse while in FEED → `err`=1 and stays 1; `vend_count` unchanged. Then assert `reset` mid-queue → all outputs return to reset values at the next edge, and no later pulses appear.

Source files
------------

// File: rtl/coin_feeder.sv
// coin_feeder
// Front end for the vending machine FSM. Each raw coin-sensor level is
// synchronised through two flops and then debounced. Every accepted coin is
// queued in a small FIFO, and the FIFO is drained as single-cycle coin1/coin2
// pulses while the machine can still take credit. Once the credit reaches 4,
// issue is blocked until the machine reports a vend on dispense.
//
// Ports:
//   clk         - single clock, rising edge
//   reset       - synchronous, active-high
//   raw_coin1   - asynchronous level from the 1-unit coin sensor
//   raw_coin2   - asynchronous level from the 2-unit coin sensor
//   dispense    - one-cycle vend indication from the vending machine
//   coin1       - registered one-cycle pulse, 1-unit coin
//   coin2       - registered one-cycle pulse, 2-unit coin
//   fifo_count  - current FIFO occupancy
//   reject      - one-cycle pulse when an accepted coin event is dropped
//   vend_count  - count of dispense pulses seen while waiting for a vend
//   err         - sticky flag, dispense seen while feeding
module coin_feeder #(
  parameter int DEPTH    = 4,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     raw_coin1,
  input  logic                     raw_coin2,
  input  logic                     dispense,
  output logic                     coin1,
  output logic                     coin2,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     reject,
  output logic [CNT_W-1:0]         vend_count,
  output logic                     err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE - 1);
  localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);

  typedef enum logic {FEED, WAIT_VEND} state_t;

  // Index 0 is the coin1 channel, index 1 is the coin2 channel.
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    armed;
  logic [DW-1:0] db_cnt [2];
  logic [1:0]    ev;

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  state_t        state;
  logic [2:0]    credit;

  logic          pop;
  logic          push;
  logic          push_ok;
  logic          drop;
  logic          full;
  logic          head;
  logic [2:0]    new_credit;

  assign raw = {raw_coin2, raw_coin1};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // The level that advances a channel's counter equals its armed bit: an
  // armed channel counts high cycles, a disarmed channel counts low cycles.
  // Reaching DEBOUNCE toggles the armed state, which gives one event per
  // sensor high period.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed     <= 2'b11;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == armed[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db_cnt[i] <= '0;
            armed[i]  <= ~armed[i];
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // An event is the cycle in which an armed channel's counter is about to
  // reach DEBOUNCE, so the push lands on the same edge that disarms it.
  assign ev[0] = armed[0] & sync2[0] & (db_cnt[0] == DB_LAST);
  assign ev[1] = armed[1] & sync2[1] & (db_cnt[1] == DB_LAST);

  assign full       = (fifo_count == FULL);
  assign head       = mem[rd_ptr];
  assign pop        = (state == FEED) && (fifo_count != '0);
  assign push       = ev[0] | ev[1];
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push_ok    = push && (!full || pop);
  // A coin1 event that coincides with a coin2 event is always lost.
  assign drop       = (ev[0] & ev[1]) || (push && full && !pop);
  assign new_credit = credit + (head ? 3'd2 : 3'd1);

  // Entries are 1 bit: 0 = coin1, 1 = coin2 (coin2 wins a same-cycle tie).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      reject     <= 1'b0;
    end else begin
      reject <= drop;
      if (push_ok) begin
        mem[wr_ptr] <= ev[1];
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Credit mirrors the machine's accumulated value. It stays within 0..5
  // because issue stops as soon as it reaches 4.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FEED;
      credit     <= '0;
      coin1      <= 1'b0;
      coin2      <= 1'b0;
      vend_count <= '0;
      err        <= 1'b0;
    end else begin
      coin1 <= 1'b0;
      coin2 <= 1'b0;
      case (state)
        FEED: begin
          if (dispense) begin
            err <= 1'b1;
          end
          if (pop) begin
            coin1  <= ~head;
            coin2  <= head;
            credit <= new_credit;
            if (new_credit >= 3'd4) begin
              state <= WAIT_VEND;
            end
          end
        end
        WAIT_VEND: begin
          if (dispense) begin
            credit     <= '0;
            vend_count <= vend_count + 1'b1;
            state      <= FEED;
          end
        end
        default: state <= FEED;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_feeder.sv
// tb_coin_feeder
// Testbench for coin_feeder. Directed stimulus pushes the expected
// {reject, coin2, coin1} pattern of every output event into a queue. A
// separate negedge monitor pops that queue whenever the DUT raises any of
// those outputs. Occupancy, vend count, err and pulse timing are also
// compared directly at hand-computed points.
module tb_coin_feeder;

  localparam int DEPTH    = 4;
  localparam int DEBOUNCE = 4;
  localparam int CNT_W    = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   raw_coin1;
  logic                   raw_coin2;
  logic                   dispense;
  logic                   coin1;
  logic                   coin2;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   reject;
  logic [CNT_W-1:0]       vend_count;
  logic                   err;

  logic [2:0] exp_q [$];
  logic [2:0] obs;
  logic [2:0] exp_val;
  int         checks = 0;
  int         errors = 0;

  coin_feeder #(.DEPTH(DEPTH), .DEBOUNCE(DEBOUNCE), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .raw_coin1  (raw_coin1),
    .raw_coin2  (raw_coin2),
    .dispense   (dispense),
    .coin1      (coin1),
    .coin2      (coin2),
    .fifo_count (fifo_count),
    .reject     (reject),
    .vend_count (vend_count),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // coins = {coin2, coin1} raw levels, held high then low for the given cycles.
  task automatic applyStimulus(input logic [1:0] coins, input int high_cycles, input int low_cycles);
    {raw_coin2, raw_coin1} = coins;
    waitCycles(high_cycles);
    {raw_coin2, raw_coin1} = 2'b00;
    waitCycles(low_cycles);
  endtask

  task automatic pulseDispense();
    dispense = 1'b1;
    waitCycles(1);
    dispense = 1'b0;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    obs = {reject, coin2, coin1};
    if (obs != 3'b000) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", int'(obs), 0);
      end else begin
        exp_val = exp_q.pop_front();
        checkOutput("scoreboard_output", int'(obs), int'(exp_val));
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    reset     = 1'b1;
    raw_coin1 = 1'b0;
    raw_coin2 = 1'b0;
    dispense  = 1'b0;
    waitCycles(2);
    $display("[TB] reset values");
    checkOutput("reset_coin1", int'(coin1), 0);
    checkOutput("reset_coin2", int'(coin2), 0);
    checkOutput("reset_reject", int'(reject), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_vend_count", int'(vend_count), 0);
    checkOutput("reset_fifo_count", int'(fifo_count), 0);
    reset = 1'b0;
    waitCycles(2);

    $display("[TB] single coin1, accept latency");
    exp_q.push_back(3'b001);
    raw_coin1 = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checkOutput("lat_fifo_count_e5", int'(fifo_count), 1);
    checkOutput("lat_coin1_e5", int'(coin1), 0);
    waitCycles(1);
    checkOutput("lat_coin1_e6", int'(coin1), 1);
    checkOutput("lat_fifo_count_e6", int'(fifo_count), 0);
    waitCycles(13);
    raw_coin1 = 1'b0;
    waitCycles(10);
    checkOutput("single_fifo_count", int'(fifo_count), 0);

    $display("[TB] coin2 glitch");
    applyStimulus(2'b10, 3, 10);
    checkOutput("glitch_fifo_count", int'(fifo_count), 0);

    $display("[TB] coin2, coin2, coin1 then dispense");
    reset = 1'b1;
    waitCycles(1);
    reset = 1'b0;
    exp_q.push_back(3'b010);
    applyStimulus(2'b10, 6, 10);
    exp_q.push_back(3'b010);
    applyStimulus(2'b10, 6, 10);
    checkOutput("wait_fifo_count_0", int'(fifo_count), 0);
    applyStimulus(2'b01, 6, 10);
    checkOutput("wait_fifo_count_1", int'(fifo_count), 1);
    waitCycles(5);
    checkOutput("wait_fifo_count_held", int'(fifo_count), 1);
    exp_q.push_back(3'b001);
    pulseDispense();
    checkOutput("disp_coin1_t1", int'(coin1), 0);
    checkOutput("disp_vend_count", int'(vend_count), 1);
    waitCycles(1);
    checkOutput("disp_coin1_t2", int'(coin1), 1);
    waitCycles(4);

    $display("[TB] fill FIFO while waiting for vend");
    exp_q.push_back(3'b010);
    applyStimulus(2'b10, 6, 10);
    exp_q.push_back(3'b010);
    applyStimulus(2'b10, 6, 10);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(2'b01, 6, 10);
    end
    exp_q.push_back(3'b100);
    applyStimulus(2'b01, 6, 10);
    checkOutput("full_fifo_count", int'(fifo_count), DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(3'b001);
    end
    pulseDispense();
    waitCycles(10);
    checkOutput("drain_fifo_count", int'(fifo_count), 0);
    checkOutput("drain_vend_count", int'(vend_count), 2);
    pulseDispense();
    checkOutput("second_vend_count", int'(vend_count), 3);
    waitCycles(3);

    $display("[TB] simultaneous coin1 and coin2");
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b010);
    applyStimulus(2'b11, 6, 10);
    checkOutput("both_fifo_count", int'(fifo_count), 0);

    $display("[TB] dispense while feeding, then reset mid-queue");
    pulseDispense();
    checkOutput("feed_disp_err", int'(err), 1);
    checkOutput("feed_disp_vend_count", int'(vend_count), 3);
    waitCycles(5);
    checkOutput("err_sticky", int'(err), 1);
    exp_q.push_back(3'b010);
    applyStimulus(2'b10, 6, 10);
    applyStimulus(2'b01, 6, 10);
    checkOutput("pre_reset_fifo_count", int'(fifo_count), 1);
    reset = 1'b1;
    waitCycles(1);
    checkOutput("mid_reset_coin1", int'(coin1), 0);
    checkOutput("mid_reset_coin2", int'(coin2), 0);
    checkOutput("mid_reset_reject", int'(reject), 0);
    checkOutput("mid_reset_err", int'(err), 0);
    checkOutput("mid_reset_vend_count", int'(vend_count), 0);
    checkOutput("mid_reset_fifo_count", int'(fifo_count), 0);
    reset = 1'b0;
    waitCycles(20);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
